// File: rtl/shift_pkg.sv
// Shared definitions for the shift unit arbiter.
//   shift_op_e : operation encoding carried with each request
//   SHAMT_W    : width of a shift amount for a 32-bit operand
//   bit_rev32  : 32-bit bit reversal, used to turn a left shift into a right shift
package shift_pkg;

  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_RSV = 2'b11
  } shift_op_e;

  function automatic logic [31:0] bit_rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = x[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational 32-bit left shifter with zero fill.
//   a : operand
//   n : shift amount (0..31)
//   y : a << n
// Built as a mux over 32 pre-shifted copies of the operand.
module shift_core
  import shift_pkg::*;
(
  input  logic [31:0]        a,
  input  logic [SHAMT_W-1:0] n,
  output logic [31:0]        y
);

  logic [31:0] pre [32];

  for (genvar k = 0; k < 32; k++) begin : g_pre
    assign pre[k] = a << k;
  end

  assign y = pre[n];

endmodule

// File: rtl/shift_unit_arbiter.sv
// Shares one 32-bit shift datapath between two requesters (0 = integer ALU
// pipe, 1 = load/store byte-alignment path) with round-robin arbitration and
// a two-stage pipeline (S1 = operand register, S2 = result register).
//   i_clk, i_reset           : clock, asynchronous active-high reset
//   i_req_valid/o_req_ready  : per-requester request handshake
//   i_req_data/shamt/op/tag  : per-requester payload
//   o_res_valid/i_res_ready  : result handshake
//   o_res_data/id/tag        : shift result, issuing requester, echoed tag
//   o_busy                   : S1 or S2 holds an entry
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A requester holds valid and payload stable until it sees ready;
// the result side holds o_res_* stable while o_res_valid is high and
// i_res_ready is low. Ready never depends on the same-side valid of the other
// requester being dropped, so a held request is always eventually granted.
module shift_unit_arbiter
  import shift_pkg::*;
#(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [1:0]                    i_req_valid,
  output logic [1:0]                    o_req_ready,
  input  logic [1:0][DATA_W-1:0]        i_req_data,
  input  logic [1:0][SHAMT_W-1:0]       i_req_shamt,
  input  logic [1:0][1:0]               i_req_op,
  input  logic [1:0][TAG_W-1:0]         i_req_tag,
  output logic                          o_res_valid,
  input  logic                          i_res_ready,
  output logic [DATA_W-1:0]             o_res_data,
  output logic                          o_res_id,
  output logic [TAG_W-1:0]              o_res_tag,
  output logic                          o_busy
);

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  // S1 stage
  logic                s1_valid;
  shift_op_e           s1_op;
  logic [31:0]         s1_data;
  logic [SHAMT_W-1:0]  s1_shamt;
  logic [TAG_W-1:0]    s1_tag;
  logic                s1_id;

  logic                rr_ptr;

  logic                s2_free;
  logic                s1_adv;
  logic                can_acc;
  logic [1:0]          grant;
  logic                gid;
  logic                accept;

  assign s2_free = !o_res_valid || i_res_ready;
  assign s1_adv  = s1_valid && s2_free;
  assign can_acc = !s1_valid || s2_free;

  // With both requesters valid, rr_ptr picks; otherwise the lone valid wins.
  always_comb begin
    grant = i_req_valid;
    if (i_req_valid == 2'b11) begin
      grant = rr_ptr ? 2'b10 : 2'b01;
    end
  end

  assign o_req_ready = can_acc ? grant : 2'b00;
  assign gid         = grant[1];
  assign accept      = |(i_req_valid & o_req_ready);
  assign o_busy      = s1_valid || o_res_valid;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_op    <= SH_SLL;
      s1_data  <= '0;
      s1_shamt <= '0;
      s1_tag   <= '0;
      s1_id    <= 1'b0;
      rr_ptr   <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_op    <= shift_op_e'(i_req_op[gid]);
        s1_data  <= i_req_data[gid][31:0];
        s1_shamt <= i_req_shamt[gid];
        s1_tag   <= i_req_tag[gid];
        s1_id    <= gid;
        rr_ptr   <= ~gid;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Right shifts reuse the left shifter on the bit-reversed operand. SRA
  // ORs in a sign-fill mask: the top n bits set, derived by reversing
  // (ONES << n) and inverting it.
  logic [31:0] core_in;
  logic [31:0] core_out;
  logic [31:0] mask_out;
  logic [31:0] srl_val;
  logic [31:0] sign_fill;
  logic [31:0] result;

  assign core_in = (s1_op == SH_SLL) ? s1_data : bit_rev32(s1_data);

  shift_core u_core_data (
    .a (core_in),
    .n (s1_shamt),
    .y (core_out)
  );

  shift_core u_core_mask (
    .a (ONES),
    .n (s1_shamt),
    .y (mask_out)
  );

  assign srl_val   = bit_rev32(core_out);
  assign sign_fill = s1_data[31] ? ~bit_rev32(mask_out) : 32'h0;

  always_comb begin
    result = 32'h0;
    case (s1_op)
      SH_SLL:  result = core_out;
      SH_SRL:  result = srl_val;
      SH_SRA:  result = srl_val | sign_fill;
      default: result = 32'h0;
    endcase
  end

  // S2 stage doubles as the output register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_res_valid <= 1'b0;
      o_res_data  <= '0;
      o_res_id    <= 1'b0;
      o_res_tag   <= '0;
    end else begin
      if (s1_adv) begin
        o_res_valid <= 1'b1;
        o_res_data  <= DATA_W'(result);
        o_res_id    <= s1_id;
        o_res_tag   <= s1_tag;
      end else if (i_res_ready) begin
        o_res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
module tb_shift_unit_arbiter;

  localparam int TAG_W = 4;
  localparam int W     = 1 + TAG_W + 32;

  logic                  i_clk = 1'b0;
  logic                  i_reset = 1'b1;
  logic [1:0]            i_req_valid = '0;
  logic [1:0]            o_req_ready;
  logic [1:0][31:0]      i_req_data = '0;
  logic [1:0][4:0]       i_req_shamt = '0;
  logic [1:0][1:0]       i_req_op = '0;
  logic [1:0][TAG_W-1:0] i_req_tag = '0;
  logic                  o_res_valid;
  logic                  i_res_ready = 1'b0;
  logic [31:0]           o_res_data;
  logic                  o_res_id;
  logic [TAG_W-1:0]      o_res_tag;
  logic                  o_busy;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  shift_unit_arbiter #(.TAG_W(TAG_W), .DATA_W(32)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_data  (i_req_data),
    .i_req_shamt (i_req_shamt),
    .i_req_op    (i_req_op),
    .i_req_tag   (i_req_tag),
    .o_res_valid (o_res_valid),
    .i_res_ready (i_res_ready),
    .o_res_data  (o_res_data),
    .o_res_id    (o_res_id),
    .o_res_tag   (o_res_tag),
    .o_busy      (o_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset;
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] n,
                                            input logic [1:0] op);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      2'b00:   return a << n;
      2'b01:   return a >> n;
      2'b10:   return sa >>> n;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic clear_reqs;
    i_req_valid = '0;
    i_req_data  = '0;
    i_req_shamt = '0;
    i_req_op    = '0;
    i_req_tag   = '0;
  endtask

  task automatic set_req(input int k, input logic [31:0] d, input logic [4:0] n,
                         input logic [1:0] op, input logic [TAG_W-1:0] tag);
    i_req_valid[k] = 1'b1;
    i_req_data[k]  = d;
    i_req_shamt[k] = n;
    i_req_op[k]    = op;
    i_req_tag[k]   = tag;
  endtask

  // Scoreboard feed: record every accepted request with its expected result.
  task automatic capture_accepts(output logic [1:0] acc);
    acc = i_req_valid & o_req_ready;
    for (int k = 0; k < 2; k++) begin
      if (acc[k]) begin
        exp_q.push_back({1'(k), i_req_tag[k],
                         ref_shift(i_req_data[k], i_req_shamt[k], i_req_op[k])});
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    clear_reqs();
    i_reset = 1'b1;
    step();
    step();
    checks++;
    if (o_res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", o_res_valid); end
    checks++;
    if (o_res_data !== 32'h0) begin failures++; $display("FAIL reset_res_data got=%h exp=0", o_res_data); end
    checks++;
    if (o_res_id !== 1'b0 || o_res_tag !== '0) begin
      failures++; $display("FAIL reset_id_tag got=%b/%h exp=0/0", o_res_id, o_res_tag);
    end
    checks++;
    if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    i_reset = 1'b0;
    #1;
    checks++;
    if (o_req_ready !== 2'b00) begin failures++; $display("FAIL reset_idle_ready got=%b exp=00", o_req_ready); end
  endtask

  task automatic test_single_sra;
    i_res_ready = 1'b1;
    set_req(0, 32'h8000_00F0, 5'd4, 2'b10, 4'd3);
    #1;
    checks++;
    if (o_req_ready !== 2'b01) begin failures++; $display("FAIL sra_ready got=%b exp=01", o_req_ready); end
    step();
    clear_reqs();
    checks++;
    if (o_res_valid !== 1'b0 || o_busy !== 1'b1) begin
      failures++; $display("FAIL sra_stage1 got valid=%b busy=%b exp valid=0 busy=1", o_res_valid, o_busy);
    end
    step();
    checks++;
    if ({o_res_valid, o_res_id, o_res_tag, o_res_data} !== {1'b1, 1'b0, 4'd3, 32'hF800_000F}) begin
      failures++;
      $display("FAIL sra_result got v=%b id=%b tag=%h data=%h exp v=1 id=0 tag=3 data=f800000f",
               o_res_valid, o_res_id, o_res_tag, o_res_data);
    end
    step();
    checks++;
    if (o_res_valid !== 1'b0 || o_busy !== 1'b0) begin
      failures++; $display("FAIL sra_retire got valid=%b busy=%b exp 0/0", o_res_valid, o_busy);
    end
  endtask

  task automatic test_boundaries;
    logic [31:0] vd [9] = '{32'h1, 32'h8000_0000, 32'h8000_0000, 32'hA5A5_1234, 32'h8765_4321,
                            32'h8765_4321, 32'hDEAD_BEEF, 32'hFFFF_0000, 32'h7FFF_0000};
    logic [4:0]  vn [9] = '{5'd31, 5'd31, 5'd31, 5'd0, 5'd0, 5'd0, 5'd3, 5'd16, 5'd16};
    logic [1:0]  vo [9] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b10};
    logic [31:0] ve [9] = '{32'h8000_0000, 32'h1, 32'hFFFF_FFFF, 32'hA5A5_1234, 32'h8765_4321,
                            32'h8765_4321, 32'h0, 32'hFFFF_FFFF, 32'h0000_7FFF};
    i_res_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_req(1, vd[i], vn[i], vo[i], TAG_W'(i + 5));
      step();
      clear_reqs();
      step();
      checks++;
      if ({o_res_valid, o_res_id, o_res_tag, o_res_data} !== {1'b1, 1'b1, TAG_W'(i + 5), ve[i]}) begin
        failures++;
        $display("FAIL boundary_%0d got v=%b id=%b tag=%h data=%h exp v=1 id=1 tag=%h data=%h",
                 i, o_res_valid, o_res_id, o_res_tag, o_res_data, TAG_W'(i + 5), ve[i]);
      end
      step();
    end
  endtask

  task automatic test_contention;
    logic [1:0]   acc;
    logic [1:0]   exp_ready;
    logic [W-1:0] exp;
    int grants = 0;
    int retired = 0;
    int n0 = 0;
    int n1 = 0;
    apply_reset();
    i_res_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (grants < 8) begin
        set_req(0, 32'h100 + 32'(n0), 5'd1, 2'b00, TAG_W'(2 * n0));
        set_req(1, 32'h200 + 32'(n1), 5'd1, 2'b01, TAG_W'(2 * n1 + 1));
      end else begin
        clear_reqs();
      end
      #1;
      if (grants < 8) begin
        exp_ready = (grants % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if (o_req_ready !== exp_ready) begin
          failures++; $display("FAIL cont_grant_%0d got=%b exp=%b", grants, o_req_ready, exp_ready);
        end
      end
      if (o_res_valid && i_res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL cont_extra_result got=%h exp=none", o_res_data);
        end else begin
          exp = exp_q.pop_front();
          if ({o_res_id, o_res_tag, o_res_data} !== exp) begin
            failures++; $display("FAIL cont_result got=%h exp=%h", {o_res_id, o_res_tag, o_res_data}, exp);
          end
        end
        retired++;
      end
      capture_accepts(acc);
      if (acc[0]) n0++;
      if (acc[1]) n1++;
      if (acc != 2'b00) grants++;
      step();
      if (grants >= 8 && retired >= 8 && !o_res_valid) break;
    end
    clear_reqs();
    checks++;
    if (retired != 8 || exp_q.size() != 0) begin
      failures++; $display("FAIL cont_count got retired=%0d left=%0d exp 8/0", retired, exp_q.size());
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] vd [4] = '{32'h1111_0001, 32'h8000_1234, 32'hF0F0_F0F0, 32'h0000_00FF};
    logic [4:0]  vn [4] = '{5'd4, 5'd8, 5'd12, 5'd2};
    logic [1:0]  vo [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic [1:0]   acc;
    logic [W-1:0] exp;
    logic [31:0]  held = '0;
    int sent = 0;
    int retired = 0;
    apply_reset();
    for (int cyc = 0; cyc < 40; cyc++) begin
      i_res_ready = (cyc >= 5);
      if (sent < 4) set_req(0, vd[sent], vn[sent], vo[sent], TAG_W'(sent + 8));
      else clear_reqs();
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        checks++;
        if (o_req_ready !== 2'b00 || sent != 2) begin
          failures++; $display("FAIL bp_stall_ready cyc=%0d got=%b sent=%0d exp=00 sent=2", cyc, o_req_ready, sent);
        end
        checks++;
        if (cyc == 2) held = o_res_data;
        else if (o_res_valid !== 1'b1 || o_res_data !== held) begin
          failures++; $display("FAIL bp_hold cyc=%0d got v=%b data=%h exp v=1 data=%h", cyc, o_res_valid, o_res_data, held);
        end
      end
      if (o_res_valid && i_res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL bp_extra_result got=%h exp=none", o_res_data);
        end else begin
          exp = exp_q.pop_front();
          if ({o_res_id, o_res_tag, o_res_data} !== exp) begin
            failures++; $display("FAIL bp_result got=%h exp=%h", {o_res_id, o_res_tag, o_res_data}, exp);
          end
        end
        retired++;
      end
      capture_accepts(acc);
      if (acc != 2'b00) sent++;
      step();
      if (sent == 4 && retired == 4) break;
    end
    clear_reqs();
    step();
    checks++;
    if (retired != 4 || exp_q.size() != 0 || o_res_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_count got retired=%0d left=%0d valid=%b exp 4/0/0", retired, exp_q.size(), o_res_valid);
    end
  endtask

  task automatic test_reset_midflight;
    apply_reset();
    i_res_ready = 1'b0;
    set_req(0, 32'h0000_00FF, 5'd4, 2'b00, 4'd5);
    step();
    set_req(0, 32'h0000_0F0F, 5'd1, 2'b01, 4'd6);
    step();
    set_req(1, 32'hCAFE_0000, 5'd2, 2'b00, 4'd7);
    checks++;
    if (o_res_valid !== 1'b1 || o_busy !== 1'b1) begin
      failures++; $display("FAIL mid_full got valid=%b busy=%b exp 1/1", o_res_valid, o_busy);
    end
    #3;
    i_reset = 1'b1;
    #1;
    checks++;
    if (o_res_valid !== 1'b0 || o_busy !== 1'b0 || o_res_data !== 32'h0 || o_res_tag !== '0) begin
      failures++;
      $display("FAIL mid_async_clear got v=%b busy=%b data=%h tag=%h exp 0/0/0/0", o_res_valid, o_busy, o_res_data, o_res_tag);
    end
    step();
    i_reset = 1'b0;
    exp_q.delete();
    set_req(0, 32'h1234_5678, 5'd8, 2'b01, 4'd9);
    #1;
    checks++;
    if (o_req_ready !== 2'b01) begin failures++; $display("FAIL mid_first_grant got=%b exp=01", o_req_ready); end
    step();
    clear_reqs();
    step();
    checks++;
    if ({o_res_valid, o_res_id, o_res_tag, o_res_data} !== {1'b1, 1'b0, 4'd9, 32'h0012_3456}) begin
      failures++;
      $display("FAIL mid_result got v=%b id=%b tag=%h data=%h exp v=1 id=0 tag=9 data=00123456",
               o_res_valid, o_res_id, o_res_tag, o_res_data);
    end
    i_res_ready = 1'b1;
    step();
    checks++;
    if (o_res_valid !== 1'b0) begin failures++; $display("FAIL mid_no_ghost got valid=%b exp=0", o_res_valid); end
  endtask

  task automatic test_random;
    logic [1:0]   acc;
    logic [1:0]   gnt;
    logic [1:0]   exp_ready;
    logic [W-1:0] exp;
    logic [W-1:0] prev_out = '0;
    logic hold_prev = 1'b0;
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;
    logic m_rr = 1'b0;
    logic s2_free;
    logic s1_adv;
    int   bad = 0;
    apply_reset();
    clear_reqs();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (!i_req_valid[k] && $urandom_range(0, 99) < 60) begin
          set_req(k, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                  TAG_W'($urandom_range(0, 15)));
        end
      end
      i_res_ready = ($urandom_range(0, 99) < 70);
      #1;
      gnt       = (i_req_valid == 2'b11) ? (m_rr ? 2'b10 : 2'b01) : i_req_valid;
      s2_free   = !m_s2 || i_res_ready;
      s1_adv    = m_s1 && s2_free;
      exp_ready = (!m_s1 || s2_free) ? gnt : 2'b00;
      checks++;
      if (o_req_ready !== exp_ready || o_res_valid !== m_s2) begin
        failures++; bad++;
        if (bad < 10) $display("FAIL rand_ctrl cyc=%0d got ready=%b valid=%b exp ready=%b valid=%b",
                               cyc, o_req_ready, o_res_valid, exp_ready, m_s2);
      end
      if (hold_prev) begin
        checks++;
        if ({o_res_id, o_res_tag, o_res_data} !== prev_out) begin
          failures++; bad++;
          if (bad < 10) $display("FAIL rand_hold cyc=%0d got=%h exp=%h", cyc, {o_res_id, o_res_tag, o_res_data}, prev_out);
        end
      end
      if (o_res_valid && i_res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; bad++;
          if (bad < 10) $display("FAIL rand_extra_result got=%h exp=none", o_res_data);
        end else begin
          exp = exp_q.pop_front();
          if ({o_res_id, o_res_tag, o_res_data} !== exp) begin
            failures++; bad++;
            if (bad < 10) $display("FAIL rand_result cyc=%0d got=%h exp=%h", cyc, {o_res_id, o_res_tag, o_res_data}, exp);
          end
        end
      end
      capture_accepts(acc);
      if (acc != 2'b00) m_rr = !acc[1];
      m_s2 = s1_adv ? 1'b1 : (i_res_ready ? 1'b0 : m_s2);
      m_s1 = (acc != 2'b00) ? 1'b1 : (s1_adv ? 1'b0 : m_s1);
      hold_prev = o_res_valid && !i_res_ready;
      prev_out  = {o_res_id, o_res_tag, o_res_data};
      step();
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) i_req_valid[k] = 1'b0;
      end
    end
    clear_reqs();
    i_res_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (o_res_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rand_drain_extra got=%h exp=none", o_res_data);
        end else begin
          exp = exp_q.pop_front();
          if ({o_res_id, o_res_tag, o_res_data} !== exp) begin
            failures++; $display("FAIL rand_drain got=%h exp=%h", {o_res_id, o_res_tag, o_res_data}, exp);
          end
        end
      end
      step();
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rand_lost got=%0d left exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_sra();
    test_boundaries();
    test_contention();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
